// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the two-port data memory arbiter.
package dmem_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port not granted last wins.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);
  always_comb begin
    valid = req0 | req1;
    grant = PORT_CPU;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = PORT_DBG;
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory port between the CPU
// load/store unit (port 0) and the debug loader (port 1); 3 cycles per access.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readData
);
  // Handshake: reqN/weN/addrN/wdataN are held by the requester until ackN pulses
  // for one cycle; reqN must be low in the cycle after ackN or it counts as new.

  state_t state, state_next;

  logic              grant, grant_valid;
  logic              port_q, we_q, oor_q, last_grant;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  always_comb begin
    sel_we    = (grant == PORT_DBG) ? we1 : we0;
    sel_addr  = (grant == PORT_DBG) ? addr1 : addr0;
    sel_wdata = (grant == PORT_DBG) ? wdata1 : wdata0;
    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    sel_oor   = {1'b0, sel_addr} >= (ADDR_W + 1)'(MEM_DEPTH);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are set on the IDLE->ACCESS edge and acks on the ACCESS->RESP edge,
  // so every output is a plain register with a one-cycle default of 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q        <= PORT_CPU;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      last_grant    <= PORT_DBG;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            port_q        <= grant;
            we_q          <= sel_we;
            oor_q         <= sel_oor;
            last_grant    <= grant;
            mem_address   <= sel_addr;
            mem_writeData <= sel_wdata;
            mem_read      <= !sel_we && !sel_oor;
            mem_write     <= sel_we && !sel_oor;
          end
        end
        ACCESS: begin
          if (port_q == PORT_DBG) begin
            ack1 <= 1'b1;
            err1 <= oor_q;
            if (!oor_q && !we_q) rdata1 <= mem_readData;
          end else begin
            ack0 <= 1'b1;
            err0 <= oor_q;
            if (!oor_q && !we_q) rdata0 <= mem_readData;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: transaction-level schedule model plus
// literal expectations for the documented scenarios.
module tb_data_mem_arbiter;
  localparam int MAXC = 2000;
  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, err0, err1, mem_read, mem_write;
  logic [7:0] rdata0, rdata1, mem_address, mem_writeData, mem_readData;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readData(mem_readData)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [7:0] mem_arr [0:DEPTH-1];
  assign mem_readData = (mem_read && mem_address < 8'(DEPTH)) ? mem_arr[mem_address[3:0]] : 8'h00;
  always @(posedge clk)
    if (mem_write && mem_address < 8'(DEPTH)) mem_arr[mem_address[3:0]] <= mem_writeData;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle, filled by a schedule model: a grant seen at
  // edge E puts its strobe in cycle E+1 and its ack in cycle E+2.
  typedef struct {
    bit       rst;
    bit       rd;
    bit       wr;
    bit [7:0] addr;
    bit [7:0] wd;
    bit       ack;
    bit       port;
    bit       upd;
    bit [7:0] rdata;
    bit       err;
  } slot_t;
  slot_t slots [0:MAXC-1];

  bit [7:0] ref_mem [0:DEPTH-1];
  bit       last_m = 1'b1;
  int       free_at = 0;

  always @(posedge clk) begin : model
    bit p, w, oor;
    bit [7:0] a, d;
    if (cyc < MAXC - 4) begin
      if (reset) begin
        for (int k = 1; k <= 3; k++) slots[cyc + k] = '{default: 0};
        slots[cyc + 1].rst = 1'b1;
        last_m  = 1'b1;
        free_at = cyc + 1;
      end else if (cyc >= free_at && (req0 || req1)) begin
        p   = (req0 && req1) ? !last_m : req1;
        w   = p ? we1 : we0;
        a   = p ? addr1 : addr0;
        d   = p ? wdata1 : wdata0;
        oor = (int'(a) >= DEPTH);
        if (!oor) begin
          slots[cyc + 1].rd   = !w;
          slots[cyc + 1].wr   = w;
          slots[cyc + 1].addr = a;
          slots[cyc + 1].wd   = d;
        end
        slots[cyc + 2].ack  = 1'b1;
        slots[cyc + 2].port = p;
        slots[cyc + 2].err  = oor;
        slots[cyc + 2].upd  = !w && !oor;
        if (!w && !oor) slots[cyc + 2].rdata = ref_mem[a];
        if (w && !oor) ref_mem[a] = d;
        last_m  = p;
        free_at = cyc + 3;
      end
    end
    cyc = cyc + 1;
  end

  bit [7:0] cur_rd0 = 0, cur_rd1 = 0;

  always @(negedge clk) begin : compare
    slot_t s;
    if (mem_read) rd_pulses++;
    if (mem_write) wr_pulses++;
    if (cyc >= 1 && cyc < MAXC) begin
      s = slots[cyc];
      if (s.rst) begin
        cur_rd0 = 0;
        cur_rd1 = 0;
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_mem_writeData", 32'(mem_writeData), 0);
      end
      if (s.ack && s.upd) begin
        if (s.port) cur_rd1 = s.rdata;
        else        cur_rd0 = s.rdata;
      end
      chk("mem_read", 32'(mem_read), 32'(s.rd));
      chk("mem_write", 32'(mem_write), 32'(s.wr));
      if (s.rd || s.wr) begin
        chk("mem_address", 32'(mem_address), 32'(s.addr));
        chk("mem_writeData", 32'(mem_writeData), 32'(s.wd));
      end
      chk("ack0", 32'(ack0), 32'(s.ack && !s.port));
      chk("ack1", 32'(ack1), 32'(s.ack && s.port));
      chk("err0", 32'(err0), 32'(s.ack && !s.port && s.err));
      chk("err1", 32'(err1), 32'(s.ack && s.port && s.err));
      chk("rdata0", 32'(rdata0), 32'(cur_rd0));
      chk("rdata1", 32'(rdata1), 32'(cur_rd1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit p, input bit w, input bit [7:0] a, input bit [7:0] d,
                        output int start_c, output int ack_c,
                        output bit [7:0] rd, output bit er);
    @(negedge clk);
    start_c = cyc;
    ack_c = -1;
    rd = 0;
    er = 0;
    if (p) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    for (int i = 0; i < 40 && ack_c < 0; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) begin
        ack_c = cyc;
        rd = p ? rdata1 : rdata0;
        er = p ? err1 : err0;
      end
    end
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
    if (ack_c < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port %0d: got no ack expected ack within 40 cycles", p);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int s0, a0, s1, a1, pw, pr;
  bit [7:0] r0, r1;
  bit e0, e1;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_arr[1] = 8'h21; ref_mem[1] = 8'h21;
    mem_arr[2] = 8'h32; ref_mem[2] = 8'h32;
    mem_arr[4] = 8'h11; ref_mem[4] = 8'h11;
    mem_arr[9] = 8'h99; ref_mem[9] = 8'h99;

    repeat (2) @(negedge clk);
    chk("reset_ack0", 32'(ack0), 0);
    chk("reset_rdata1", 32'(rdata1), 0);
    chk("reset_mem_address", 32'(mem_address), 0);
    reset = 1'b0;

    // Port 0 write then read back
    pw = wr_pulses;
    do_req(1'b0, 1'b1, 8'd3, 8'hA5, s0, a0, r0, e0);
    chk("write_latency", 32'(a0 - s0), 2);
    chk("write_pulse_count", 32'(wr_pulses - pw), 1);
    do_req(1'b0, 1'b0, 8'd3, 8'h00, s0, a0, r0, e0);
    chk("readback_rdata0", 32'(r0), 32'h A5);
    chk("readback_err0", 32'(e0), 0);

    // Simultaneous requests from reset: port 0 first
    do_reset();
    fork
      do_req(1'b0, 1'b0, 8'd1, 8'h00, s0, a0, r0, e0);
      do_req(1'b1, 1'b0, 8'd2, 8'h00, s1, a1, r1, e1);
    join
    chk("tie_from_reset_p0_first", 32'(a0 < a1), 1);
    chk("tie_p0_rdata", 32'(r0), 32'h21);
    chk("tie_p1_rdata", 32'(r1), 32'h32);
    // Port 0 is granted last, so the next tie goes to port 1
    do_req(1'b0, 1'b0, 8'd1, 8'h00, s0, a0, r0, e0);
    fork
      do_req(1'b0, 1'b0, 8'd2, 8'h00, s0, a0, r0, e0);
      do_req(1'b1, 1'b0, 8'd1, 8'h00, s1, a1, r1, e1);
    join
    chk("tie_repeat_p1_first", 32'(a1 < a0), 1);
    chk("tie_repeat_gap", 32'(a0 - a1), 3);

    // Out-of-range write from port 1
    pw = wr_pulses;
    pr = rd_pulses;
    do_req(1'b1, 1'b1, 8'd10, 8'h3C, s1, a1, r1, e1);
    chk("oor_no_write", 32'(wr_pulses - pw), 0);
    chk("oor_no_read", 32'(rd_pulses - pr), 0);
    chk("oor_err1", 32'(e1), 1);
    do_req(1'b1, 1'b0, 8'd9, 8'h00, s1, a1, r1, e1);
    chk("after_oor_rdata1", 32'(r1), 32'h99);
    chk("after_oor_err1", 32'(e1), 0);

    // Port 1 holding its request while port 0 issues back-to-back reads
    fork
      for (int i = 0; i < 3; i++) begin
        int ss, aa;
        bit [7:0] rr;
        bit ee;
        do_req(1'b0, 1'b0, 8'd4, 8'h00, ss, aa, rr, ee);
        chk("contend_wait_p0", 32'(aa - ss <= 5), 1);
      end
      for (int j = 0; j < 3; j++) begin
        int ss, aa;
        bit [7:0] rr;
        bit ee;
        do_req(1'b1, 1'b0, 8'd2, 8'h00, ss, aa, rr, ee);
        chk("contend_wait_p1", 32'(aa - ss <= 5), 1);
      end
    join

    // Reset during the ACCESS cycle of a port 0 write
    @(negedge clk);
    we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'h5A; req0 = 1'b1;
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    chk("abort_reached_access", 32'(mem_write), 1);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_mem_write", 32'(mem_write), 0);
    chk("abort_ack0", 32'(ack0), 0);
    chk("abort_mem_address", 32'(mem_address), 0);
    chk("abort_rdata0", 32'(rdata0), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack0", 32'(ack0), 0);
    end
    do_req(1'b0, 1'b1, 8'd5, 8'h5A, s0, a0, r0, e0);
    chk("retry_latency", 32'(a0 - s0), 2);
    do_req(1'b0, 1'b0, 8'd5, 8'h00, s0, a0, r0, e0);
    chk("retry_readback", 32'(r0), 32'h5A);

    // Write ack keeps the previous read data
    do_req(1'b1, 1'b0, 8'd9, 8'h00, s1, a1, r1, e1);
    do_req(1'b0, 1'b0, 8'd4, 8'h00, s0, a0, r0, e0);
    chk("read4_rdata0", 32'(r0), 32'h11);
    do_req(1'b0, 1'b1, 8'd4, 8'h77, s0, a0, r0, e0);
    chk("write_holds_rdata0", 32'(r0), 32'h11);
    chk("rdata1_unchanged", 32'(rdata1), 32'h99);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
